cab_master: RTL and testbench

- Host-side bridge that turns a 32-bit register access into the 16-bit CAB request word stream, and collects the two-beat CAB read acknowledgement.
- Sits directly upstream of the CAB slave: drives cab_xx_req_vld/cab_xx_req_data and consumes xx_cab_ack_vld/xx_cab_ack_data/xx_cab_rdy.
- Adds a read timeout so a dead slave cannot hang the host.

---
 rtl/cab_master_if.sv | 32 +++
 rtl/cab_master.sv | 144 ++++++++++++++
 tb/tb_cab_master.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cab_master_if.sv
// Host register-access port and CAB request/ack bus as seen by cab_master.
// The master modport is the bridge itself; the slave modport is the host/CAB side.
interface cab_master_if;
  logic        host_req;
  logic        host_wr;
  logic        host_ctrl;
  logic [13:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        host_err;
  logic        host_busy;
  logic        cab_xx_req_vld;
  logic [15:0] cab_xx_req_data;
  logic        xx_cab_ack_vld;
  logic [15:0] xx_cab_ack_data;
  logic        xx_cab_rdy;

  modport master (
    input  host_req, host_wr, host_ctrl, host_addr, host_wdata,
    input  xx_cab_ack_vld, xx_cab_ack_data, xx_cab_rdy,
    output host_ack, host_rdata, host_err, host_busy,
    output cab_xx_req_vld, cab_xx_req_data
  );

  modport slave (
    output host_req, host_wr, host_ctrl, host_addr, host_wdata,
    output xx_cab_ack_vld, xx_cab_ack_data, xx_cab_rdy,
    input  host_ack, host_rdata, host_err, host_busy,
    input  cab_xx_req_vld, cab_xx_req_data
  );
endinterface

// File: rtl/cab_master.sv
// Bridges a 32-bit host register access onto the 16-bit CAB request stream and
// collects the two-beat read acknowledgement, with a read timeout.
module cab_master #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          clk,
  input  logic          rst_n,
  cab_master_if.master  bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_LO   = 3'd1;
  localparam logic [2:0] WR_HI   = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] RD_HI   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  // DONE plus the registered ack take the last two cycles of the window, so
  // host_ack lands exactly TIMEOUT cycles after the header.
  localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT - 2);

  logic [2:0]    state_q, state_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          guard_q;
  logic          vld_q, vld_d;
  logic [15:0]   data_q, data_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   res_q, res_d;
  logic          res_err_q, res_err_d;
  logic          busy_q;
  logic          accept;

  // guard_q blocks issue for one cycle after any ack word, so a stale pair
  // can never overlap a freshly issued header.
  assign accept = (state_q == IDLE) && bus.host_req && bus.xx_cab_rdy &&
                  !bus.xx_cab_ack_vld && !guard_q;

  always_comb begin
    state_d   = state_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    vld_d     = 1'b0;
    data_d    = 16'h0;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    res_d     = res_q;
    res_err_d = res_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wdata_d   = bus.host_wdata;
          vld_d     = 1'b1;
          data_d    = {bus.host_addr, bus.host_ctrl, bus.host_wr};
          cnt_d     = '0;
          res_d     = 32'h0;
          res_err_d = 1'b0;
          state_d   = bus.host_wr ? WR_LO : RD_WAIT;
        end
      end
      WR_LO: begin
        vld_d   = 1'b1;
        data_d  = wdata_q[15:0];
        state_d = WR_HI;
      end
      WR_HI: begin
        vld_d     = 1'b1;
        data_d    = wdata_q[31:16];
        res_err_d = 1'b0;
        state_d   = DONE;
      end
      RD_WAIT: begin
        if (bus.xx_cab_ack_vld) begin
          res_d[15:0] = bus.xx_cab_ack_data;
          state_d     = RD_HI;
        end else if (cnt_q == CNT_FIRE) begin
          res_d     = ERR_DATA;
          res_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_HI: begin
        if (bus.xx_cab_ack_vld) begin
          res_d[31:16] = bus.xx_cab_ack_data;
          res_err_d    = 1'b0;
        end else begin
          res_d[31:16] = 16'h0;
          res_err_d    = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        ack_d   = 1'b1;
        rdata_d = res_q;
        err_d   = res_err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wdata_q   <= 32'h0;
      cnt_q     <= '0;
      guard_q   <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= 16'h0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      res_q     <= 32'h0;
      res_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      guard_q   <= bus.xx_cab_ack_vld;
      vld_q     <= vld_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      res_q     <= res_d;
      res_err_q <= res_err_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.cab_xx_req_vld  = vld_q;
  assign bus.cab_xx_req_data = data_q;
  assign bus.host_ack        = ack_q;
  assign bus.host_rdata      = rdata_q;
  assign bus.host_err        = err_q;
  assign bus.host_busy       = busy_q;
endmodule

// File: tb/tb_cab_master.sv
// Scoreboard bench for cab_master: stimulus pushes expected CAB words and host
// acks (with the cycle they must appear in); a negedge monitor pops and compares.
module tb_cab_master;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cab_master_if bus();

  cab_master #(.TIMEOUT(TMO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          kind;      // 0 = CAB request word, 1 = host ack
    logic [31:0] data;
    logic        err;
    int          cyc;
    bit          chk_data;
  } exp_t;
  exp_t q[$];

  task automatic push(bit k, logic [31:0] d, logic e, int c, bit cd);
    exp_t x;
    x.kind = k; x.data = d; x.err = e; x.cyc = c; x.chk_data = cd;
    q.push_back(x);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_evt(bit k, logic [31:0] d, logic e);
    exp_t x;
    bit   ok;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got data=%h err=%b at cycle %0d, want nothing", k ? "ack" : "word", d, e, cyc);
    end else begin
      x  = q.pop_front();
      ok = (x.kind == k) && (x.cyc == cyc) && (!x.chk_data || d === x.data) && (!k || e === x.err);
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d data=%h err=%b cyc=%0d want kind=%0d data=%h err=%b cyc=%0d",
                 k ? "ack" : "word", k, d, e, cyc, x.kind, x.data, x.err, x.cyc);
      end
    end
  endtask

  // Monitor: every request word and every host_ack must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cab_xx_req_vld) check_evt(1'b0, {16'h0, bus.cab_xx_req_data}, 1'b0);
      else                    chk("idle_bus", {16'h0, bus.cab_xx_req_data}, 32'h0);
      if (bus.host_ack)       check_evt(1'b1, bus.host_rdata, bus.host_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) tick();
  endtask

  task automatic issue(bit wr, bit ctrl, logic [13:0] addr, logic [31:0] wd);
    bus.host_wr    = wr;
    bus.host_ctrl  = ctrl;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
    bus.host_req   = 1'b1;
  endtask

  // Host drops req in the same cycle it sees host_ack.
  task automatic wait_ack(string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.host_ack;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no host_ack within 40 cycles (cycle %0d)", nm, cyc);
    end
    bus.host_req = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, h, a, c;
    bus.host_req = 0; bus.host_wr = 0; bus.host_ctrl = 0;
    bus.host_addr = '0; bus.host_wdata = '0;
    bus.xx_cab_ack_vld = 0; bus.xx_cab_ack_data = '0; bus.xx_cab_rdy = 0;

    // Reset state
    tick(); tick();
    chk("rst_vld",   {31'h0, bus.cab_xx_req_vld}, 32'h0);
    chk("rst_data",  {16'h0, bus.cab_xx_req_data}, 32'h0);
    chk("rst_ack",   {31'h0, bus.host_ack}, 32'h0);
    chk("rst_rdata", bus.host_rdata, 32'h0);
    chk("rst_err",   {31'h0, bus.host_err}, 32'h0);
    chk("rst_busy",  {31'h0, bus.host_busy}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Write: header {0x0123,0,1}=048D, then low and high halves, ack one cycle later
    tick(); t0 = cyc;
    issue(1'b1, 1'b0, 14'h0123, 32'hCAFE_F00D);
    bus.xx_cab_rdy = 1'b1;
    push(0, 32'h048D, 0, t0 + 1, 1);
    push(0, 32'hF00D, 0, t0 + 2, 1);
    push(0, 32'hCAFE, 0, t0 + 3, 1);
    push(1, 32'h0,    0, t0 + 4, 0);
    wait_ack("wr_basic");

    // Read: header FFFE, ack pair 5 cycles after header; req drops and inputs change mid-flight
    tick(); t0 = cyc;
    issue(1'b0, 1'b1, 14'h3FFF, 32'h0);
    h = t0 + 1;
    push(0, 32'hFFFE, 0, h, 1);
    tick();
    bus.host_req = 1'b0; bus.host_addr = 14'h0; bus.host_wr = 1'b1;
    wait_cyc(h + 5);
    bus.xx_cab_ack_vld = 1'b1; bus.xx_cab_ack_data = 16'h5678;
    tick();
    bus.xx_cab_ack_data = 16'h1234;
    tick();
    bus.xx_cab_ack_vld = 1'b0; bus.xx_cab_ack_data = 16'h0;
    push(1, 32'h1234_5678, 0, h + 8, 1);
    wait_ack("rd_basic");

    // Ack arriving on the same cycle the timeout would fire: ack wins
    tick(); t0 = cyc;
    issue(1'b0, 1'b0, 14'h0005, 32'h0);
    h = t0 + 1;
    push(0, 32'h0014, 0, h, 1);
    wait_cyc(h + TMO - 2);
    bus.xx_cab_ack_vld = 1'b1; bus.xx_cab_ack_data = 16'hAAAA;
    tick();
    bus.xx_cab_ack_data = 16'h5555;
    tick();
    bus.xx_cab_ack_vld = 1'b0; bus.xx_cab_ack_data = 16'h0;
    push(1, 32'h5555_AAAA, 0, h + 9, 1);
    wait_ack("rd_ack_vs_timeout");

    // Timeout: no ack, host_ack TMO cycles after header with ERR_DATA
    tick(); t0 = cyc;
    issue(1'b0, 1'b0, 14'h0010, 32'h0);
    h = t0 + 1;
    push(0, 32'h0040, 0, h, 1);
    push(1, 32'hDEAD_BEEF, 1, h + TMO, 1);
    wait_ack("rd_timeout");
    // Queued write held off by rdy=0, then a late stale pair arrives as rdy rises.
    // Acceptance is legal two cycles after the last stale word; header one cycle later.
    bus.xx_cab_rdy = 1'b0;
    issue(1'b1, 1'b1, 14'h0002, 32'h1111_2222);
    wait_cyc(h + TMO + 3);
    a = cyc;
    push(0, 32'h000B, 0, a + 4, 1);
    push(0, 32'h2222, 0, a + 5, 1);
    push(0, 32'h1111, 0, a + 6, 1);
    push(1, 32'h0,    0, a + 7, 0);
    bus.xx_cab_rdy = 1'b1; bus.xx_cab_ack_vld = 1'b1; bus.xx_cab_ack_data = 16'hBAD0;
    tick();
    bus.xx_cab_ack_data = 16'hBAD1;
    tick();
    bus.xx_cab_ack_vld = 1'b0; bus.xx_cab_ack_data = 16'h0;
    wait_ack("wr_after_stale");

    // Back-pressure: req held with rdy=0 for 10 cycles, nothing issued and not busy
    bus.xx_cab_rdy = 1'b0;
    issue(1'b1, 1'b0, 14'h0100, 32'h0000_FFFF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_vld",  {31'h0, bus.cab_xx_req_vld}, 32'h0);
      chk("bp_busy", {31'h0, bus.host_busy}, 32'h0);
    end
    c = cyc;
    bus.xx_cab_rdy = 1'b1;
    push(0, 32'h0401, 0, c + 1, 1);
    push(0, 32'hFFFF, 0, c + 2, 1);
    push(0, 32'h0000, 0, c + 3, 1);
    push(1, 32'h0,    0, c + 4, 0);
    @(negedge clk);
    chk("bp_busy_after", {31'h0, bus.host_busy}, 32'h1);
    wait_ack("wr_backpressure");

    // Broken pair: single ack word -> err, upper half zero
    tick(); t0 = cyc;
    issue(1'b0, 1'b1, 14'h0020, 32'h0);
    h = t0 + 1;
    push(0, 32'h0082, 0, h, 1);
    push(1, 32'h0000_7777, 1, h + 5, 1);
    wait_cyc(h + 2);
    bus.xx_cab_ack_vld = 1'b1; bus.xx_cab_ack_data = 16'h7777;
    tick();
    bus.xx_cab_ack_vld = 1'b0; bus.xx_cab_ack_data = 16'h0;
    wait_ack("rd_broken_pair");

    // Reset while the header is on the bus (state WR_LO): vld drops at once, no ack
    tick();
    issue(1'b1, 1'b0, 14'h0001, 32'h89AB_CDEF);
    tick();
    #1;
    rst_n = 1'b0;
    bus.host_req = 1'b0;
    #1;
    chk("rstmid_vld",  {31'h0, bus.cab_xx_req_vld}, 32'h0);
    chk("rstmid_data", {16'h0, bus.cab_xx_req_data}, 32'h0);
    chk("rstmid_busy", {31'h0, bus.host_busy}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_ack", {31'h0, bus.host_ack}, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    tick(); t0 = cyc;
    issue(1'b1, 1'b0, 14'h0001, 32'h89AB_CDEF);
    push(0, 32'h0005, 0, t0 + 1, 1);
    push(0, 32'hCDEF, 0, t0 + 2, 1);
    push(0, 32'h89AB, 0, t0 + 3, 1);
    push(1, 32'h0,    0, t0 + 4, 0);
    wait_ack("wr_after_reset");

    repeat (5) tick();
    chk("sb_empty", q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
